// File: rtl/axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_master
// Description : AXI initiator; turns one host command into an INCR write or
//               read burst and reports done/err/resp per transaction.
//               Optional stall timeout: define AXI_MASTER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_master #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wd_in,
  input  logic              wd_in_valid,
  output logic              wd_in_ready,
  output logic [DATA_W-1:0] rd_out,
  output logic              rd_out_valid,
  output logic              done,
  output logic              err,
  output logic [1:0]        resp_out,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t     r_state;
  logic [7:0] r_len;
  logic [7:0] r_cnt;

  logic       w_in_w;
  logic       w_wfire;
  logic       w_last_cnt;
  logic [1:0] w_bresp_max;
  logic [1:0] w_rresp_max;
  logic       w_timeout;

  assign w_in_w      = (r_state == S_W);
  assign w_wfire     = w_in_w && wd_in_valid && wready;
  assign w_last_cnt  = (r_cnt == r_len);
  assign w_bresp_max = (bresp > resp_out) ? bresp : resp_out;
  assign w_rresp_max = (rresp > resp_out) ? rresp : resp_out;

  // Write data is a straight pass-through of the host stream while in W.
  assign wvalid      = w_in_w && wd_in_valid;
  assign wd_in_ready = w_in_w && wready;
  assign wdata       = w_in_w ? wd_in : '0;
  assign wlast       = w_in_w && w_last_cnt;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int c_stall_w = $clog2(TIMEOUT_CYC + 1);

  logic [c_stall_w-1:0] r_stall;
  logic                 w_busy;
  logic                 w_fire;

  assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_fire = (awvalid && awready) || w_wfire || (bvalid && bready) ||
                  (arvalid && arready) || (rvalid && rready);
  assign w_timeout = w_busy && !w_fire &&
                     (r_stall == c_stall_w'(TIMEOUT_CYC - 1));

  always_ff @(posedge aclk) begin
    if (areset || !w_busy || w_fire) begin
      r_stall <= '0;
    end else begin
      r_stall <= r_stall + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      cmd_ready    <= 1'b1;
      awaddr       <= '0;
      awlen        <= '0;
      awvalid      <= 1'b0;
      bready       <= 1'b0;
      araddr       <= '0;
      arlen        <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      rd_out       <= '0;
      rd_out_valid <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      resp_out     <= 2'b00;
    end else begin
      rd_out_valid <= 1'b0;
      done         <= 1'b0;
      if (w_timeout) begin
        awvalid  <= 1'b0;
        arvalid  <= 1'b0;
        bready   <= 1'b0;
        rready   <= 1'b0;
        resp_out <= 2'b10;
        err      <= 1'b1;
        done     <= 1'b1;
        r_state  <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (cmd_valid) begin
              cmd_ready <= 1'b0;
              r_len     <= cmd_len;
              r_cnt     <= '0;
              resp_out  <= 2'b00;
              err       <= 1'b0;
              if (cmd_write) begin
                awaddr  <= cmd_addr;
                awlen   <= cmd_len;
                awvalid <= 1'b1;
                r_state <= S_AW;
              end else begin
                araddr  <= cmd_addr;
                arlen   <= cmd_len;
                arvalid <= 1'b1;
                r_state <= S_AR;
              end
            end
          end
          S_AW: begin
            if (awready) begin
              awvalid <= 1'b0;
              r_state <= S_W;
            end
          end
          S_W: begin
            if (w_wfire) begin
              if (w_last_cnt) begin
                bready  <= 1'b1;
                r_state <= S_B;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_B: begin
            if (bvalid) begin
              bready   <= 1'b0;
              resp_out <= w_bresp_max;
              err      <= (w_bresp_max != 2'b00);
              done     <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_AR: begin
            if (arready) begin
              arvalid <= 1'b0;
              rready  <= 1'b1;
              r_state <= S_R;
            end
          end
          S_R: begin
            if (rvalid) begin
              rd_out       <= rdata;
              rd_out_valid <= 1'b1;
              resp_out     <= w_rresp_max;
              // Burst closes on whichever of rlast / final count comes first;
              // any disagreement between the two is a protocol error.
              if (rlast || w_last_cnt) begin
                rready  <= 1'b0;
                err     <= (rlast != w_last_cnt) || (w_rresp_max != 2'b00);
                done    <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          S_DONE: begin
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_master
// Description : Self-checking bench: table-driven transactions plus read-data
//               scoreboard and hand-written stall, reset and timeout cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_master;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int c_to = 8;
`else
  localparam int c_to = 256;
`endif

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [31:0] wd_in = '0;
  logic        wd_in_valid = 1'b0, wd_in_ready;
  logic [31:0] rd_out;
  logic        rd_out_valid, done, err;
  logic [1:0]  resp_out;
  logic [31:0] awaddr, araddr, wdata;
  logic [7:0]  awlen, arlen;
  logic        awvalid, awready = 1'b0, wlast, wvalid, wready = 1'b1;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b0, rvalid = 1'b0, rready;

  axi_burst_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(c_to)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_in(wd_in), .wd_in_valid(wd_in_valid), .wd_in_ready(wd_in_ready),
    .rd_out(rd_out), .rd_out_valid(rd_out_valid),
    .done(done), .err(err), .resp_out(resp_out),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int errors = 0;
  int checks = 0;
  int t_acc  = 0;
  int t_done = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[int];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    int          bad;
    int          early;
    logic        e_err;
    logic [1:0]  e_resp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input int k);
    return mem.exists(k) ? mem[k] : (32'hDEAD0000 | 32'(k));
  endfunction

  // Read-data scoreboard: every beat handed to the host must match the queue.
  always @(negedge aclk) begin
    if (!areset && rd_out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_out unexpected beat: got %0h expected none", rd_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_out !== e) begin
          errors++;
          $display("FAIL rd_out: got %0h expected %0h", rd_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    #1;
    while (!cmd_ready && n < 20) begin tick(); #1; n++; end
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [7:0] len, input int stall);
    int n = 0;
    repeat (stall) begin
      #1;
      chk("avalid held", wr ? awvalid : arvalid, 1);
      chk("aaddr stable", wr ? awaddr : araddr, a);
      tick();
    end
    if (wr) awready = 1'b1; else arready = 1'b1;
    #1;
    while (!(wr ? awvalid : arvalid) && n < 20) begin tick(); #1; n++; end
    chk("avalid", wr ? awvalid : arvalid, 1);
    chk("aaddr", wr ? awaddr : araddr, a);
    chk("alen", wr ? awlen : arlen, len);
    tick();
    awready = 1'b0; arready = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic e_last, input int gap);
    int n = 0;
    wd_in_valid = 1'b0;
    repeat (gap) begin #1; chk("wvalid gap", wvalid, 0); tick(); end
    wd_in_valid = 1'b1; wd_in = d;
    #1;
    while (!wd_in_ready && n < 20) begin tick(); #1; n++; end
    chk("wvalid follows", wvalid, 1);
    chk("wdata", wdata, d);
    chk("wlast", wlast, e_last);
    tick();
    wd_in_valid = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] br);
    int n = 0;
    bvalid = 1'b1; bresp = br;
    #1;
    while (!bready && n < 20) begin tick(); #1; n++; end
    chk("bready", bready, 1);
    tick();
    bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic r_phase(input logic [31:0] a, input logic [7:0] len, input int bad,
                         input logic [1:0] rr, input int early);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      rvalid = 1'b1;
      rdata  = rd_mem(int'(a) + i);
      rresp  = (i == bad) ? rr : 2'b00;
      rlast  = (early < 0) ? (i == int'(len)) : (i == early);
      exp_q.push_back(rdata);
      #1;
      while (!rready && n < 20) begin tick(); #1; n++; end
      chk("rready", rready, 1);
      tick();
      if (rlast) break;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  task automatic wait_done(input logic e_err, input logic [1:0] e_resp);
    int n = 0;
    #1;
    while (!done && n < 40) begin tick(); #1; n++; end
    chk("done", done, 1);
    chk("err", err, e_err);
    chk("resp_out", resp_out, e_resp);
    t_done = cyc;
    tick();
    chk("done pulse width", done, 0);
  endtask

  task automatic run_txn(input vec_t v, input int stall, input int gap_mask);
    send_cmd(v.wr, v.addr, v.len);
    addr_phase(v.wr, v.addr, v.len, stall);
    if (v.wr) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        logic [31:0] d;
        d = $urandom;
        mem[int'(v.addr) + i] = d;
        w_beat(d, i == int'(v.len), (i < 32 && gap_mask[i]) ? 2 : 0);
      end
      b_phase(v.resp);
    end else begin
      r_phase(v.addr, v.len, v.bad, v.resp, v.early);
    end
    wait_done(v.e_err, v.e_resp);
  endtask

  initial begin
    vec_t v;
    logic [31:0] d;
    // {wr, addr, len, resp, bad beat, rlast beat (-1 normal, 99 never), err, resp}
    vecs[0] = '{1'b1, 32'h10, 8'd3, 2'b00, -1, -1, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 32'h10, 8'd3, 2'b00, -1, -1, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 32'h40, 8'd0, 2'b00, -1, -1, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 32'h40, 8'd0, 2'b00, -1, -1, 1'b0, 2'b00};
    vecs[4] = '{1'b1, 32'h50, 8'd1, 2'b10, -1, -1, 1'b1, 2'b10};
    vecs[5] = '{1'b0, 32'h10, 8'd3, 2'b01,  2, -1, 1'b1, 2'b01};
    vecs[6] = '{1'b0, 32'h10, 8'd3, 2'b00, -1,  1, 1'b1, 2'b00};
    vecs[7] = '{1'b0, 32'h50, 8'd1, 2'b11,  0, -1, 1'b1, 2'b11};
    vecs[8] = '{1'b0, 32'h10, 8'd2, 2'b00, -1, 99, 1'b1, 2'b00};

    repeat (3) tick();
    #1;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst valids", {awvalid, wvalid, arvalid, bready, rready, rd_out_valid}, 0);
    chk("rst done/err/resp", {done, err, resp_out}, 0);
    chk("rst addr/len", {awaddr, awlen}, 0);
    chk("rst wlast/wdata", {wlast, wdata}, 0);
    chk("rst rd_out", rd_out, 0);
    areset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], 0, 0);
      if (i == 0) chk("cmd accept to done cycles", t_done - t_acc, 6);
    end

    // awready stall of 5 cycles plus host gaps before beats 1 and 3.
    v = '{1'b1, 32'h20, 8'd3, 2'b00, -1, -1, 1'b0, 2'b00};
    run_txn(v, 5, 32'b0101);
    v.wr = 1'b0;
    run_txn(v, 2, 0);

    // Reset while beat 2 of a write is being offered.
    send_cmd(1'b1, 32'h80, 8'd3);
    addr_phase(1'b1, 32'h80, 8'd3, 0);
    d = $urandom;
    w_beat(d, 1'b0, 0);
    wd_in_valid = 1'b1; wd_in = 32'hCAFEF00D; areset = 1'b1;
    tick();
    #1;
    chk("midrst cmd_ready", cmd_ready, 1);
    chk("midrst valids", {awvalid, wvalid, wd_in_ready, arvalid, bready, rready}, 0);
    chk("midrst wdata/wlast", {wdata, wlast}, 0);
    chk("midrst done/err/resp", {done, err, resp_out}, 0);
    areset = 1'b0; wd_in_valid = 1'b0;
    tick();
    v = '{1'b0, 32'h20, 8'd3, 2'b00, -1, -1, 1'b0, 2'b00};
    run_txn(v, 0, 0);

`ifdef AXI_MASTER_TIMEOUT_EN
    send_cmd(1'b0, 32'h10, 8'd3);
    wait_done(1'b1, 2'b10);
    chk("timeout cycles", t_done - t_acc, 8);
    chk("timeout arvalid dropped", arvalid, 0);
`endif

    repeat (2) tick();
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
